// File: rtl/fsm_cmd_sequencer.sv
// Command front-end: accepts 3-bit commands over valid/ready and walks a 2-bit
// mode through legal transitions, with error lockout and ARMED timeout.
module fsm_cmd_sequencer #(
   parameter int unsigned MAX_ERR    = 3,
   parameter int unsigned TIMEOUT    = 16,
   parameter logic [2:0]  UNLOCK_KEY = 3'b101
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd,
   input  logic [2:0] data_in,
   output logic [1:0] mode,
   output logic [2:0] data_out,
   output logic       err,
   output logic       locked
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      ACTIVE  = 2'd2,
      LOCKOUT = 2'd3
   } mode_t;

   localparam logic [2:0] CMD_ARM   = 3'b001;
   localparam logic [2:0] CMD_GO    = 3'b010;
   localparam logic [2:0] CMD_STOP  = 3'b011;
   localparam logic [2:0] CMD_CLEAR = 3'b100;
   localparam logic [2:0] ERR_LIMIT = 3'(MAX_ERR);
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

   mode_t      mode_r;
   mode_t      mode_nxt_s;
   logic       ready_r;
   logic [2:0] data_out_r;
   logic       err_r;
   logic       locked_r;
   logic [2:0] err_cnt_r;
   logic [2:0] err_cnt_nxt_s;
   logic [7:0] to_cnt_r;
   logic [7:0] to_cnt_nxt_s;
   logic       accept_s;
   logic       illegal_s;

   // Next-state decode: command handling, error counting and ARMED timeout
   always_comb begin
      accept_s      = cmd_valid && ready_r;
      mode_nxt_s    = mode_r;
      err_cnt_nxt_s = err_cnt_r;
      to_cnt_nxt_s  = 8'd0;
      illegal_s     = 1'b0;
      if (accept_s) begin
         case (mode_r)
            IDLE: begin
               if (cmd == CMD_ARM) begin
                  mode_nxt_s = ARMED;
               end else begin
                  illegal_s = 1'b1;
               end
            end
            ARMED: begin
               if (cmd == CMD_GO) begin
                  mode_nxt_s    = ACTIVE;
                  err_cnt_nxt_s = 3'd0;
               end else if (cmd == CMD_STOP) begin
                  mode_nxt_s = IDLE;
               end else begin
                  illegal_s = 1'b1;
               end
            end
            ACTIVE: begin
               if (cmd == CMD_STOP) begin
                  mode_nxt_s = IDLE;
               end else begin
                  illegal_s = 1'b1;
               end
            end
            LOCKOUT: begin
               if ((cmd == CMD_CLEAR) && (data_in == UNLOCK_KEY)) begin
                  mode_nxt_s    = IDLE;
                  err_cnt_nxt_s = 3'd0;
               end else begin
                  illegal_s = 1'b1;
               end
            end
            default: begin
               mode_nxt_s = mode_r;
            end
         endcase
         // Saturating count; reaching the limit locks out on the same edge
         if (illegal_s) begin
            if (err_cnt_r != 3'd7) begin
               err_cnt_nxt_s = err_cnt_r + 3'd1;
            end else begin
               err_cnt_nxt_s = err_cnt_r;
            end
            if (err_cnt_nxt_s == ERR_LIMIT) begin
               mode_nxt_s = LOCKOUT;
            end else begin
               mode_nxt_s = mode_r;
            end
         end else begin
            illegal_s = 1'b0;
         end
      end else if (mode_r == ARMED) begin
         if (to_cnt_r == TO_LAST) begin
            mode_nxt_s = IDLE;
         end else begin
            to_cnt_nxt_s = to_cnt_r + 8'd1;
         end
      end else begin
         to_cnt_nxt_s = 8'd0;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r     <= IDLE;
         ready_r    <= 1'b1;
         data_out_r <= 3'd0;
         err_r      <= 1'b0;
         locked_r   <= 1'b0;
         err_cnt_r  <= 3'd0;
         to_cnt_r   <= 8'd0;
      end else begin
         mode_r     <= mode_nxt_s;
         ready_r    <= !accept_s;
         data_out_r <= (mode_r == ACTIVE) ? data_in : 3'd0;
         err_r      <= illegal_s;
         locked_r   <= (mode_nxt_s == LOCKOUT);
         err_cnt_r  <= err_cnt_nxt_s;
         to_cnt_r   <= to_cnt_nxt_s;
      end
   end

   assign cmd_ready = ready_r;
   assign mode      = mode_r;
   assign data_out  = data_out_r;
   assign err       = err_r;
   assign locked    = locked_r;

endmodule
